// File: rtl/crypto_pkg.sv
// Shared mode constants and select-width helper for the round counter bank.
package crypto_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // A single channel still needs a one-bit select port.
  function automatic int sel_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/round_counter_cell.sv
// One counter channel: clr > load > add priority, load clamp, wrap/saturate at MAX_COUNT.
// Latency: count updates on the next clk edge; wrap is a same-cycle combinational event; no backpressure.
module round_counter_cell
  import crypto_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 10,
  parameter int SATURATE  = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic             add,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             done,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] count_nxt;

  always_comb begin
    count_nxt = count;
    wrap      = 1'b0;
    if (sel) begin
      if (clr) begin
        count_nxt = '0;
      end else if (load) begin
        count_nxt = (load_val > MAX_VAL) ? MAX_VAL : load_val;
      end else if (add) begin
        if (count < MAX_VAL) begin
          count_nxt = count + 1'b1;
        end else if (SATURATE == MODE_WRAP) begin
          count_nxt = '0;
          wrap      = 1'b1;
        end else begin
          count_nxt = MAX_VAL;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

  assign done = (count == MAX_VAL);

endmodule

// File: rtl/round_counter_bank.sv
// Bank of CHANNELS round counters with a registered show port and a registered any-channel wrap pulse.
// Latency: count_out/count_valid/wrap_pulse one cycle after the request, done is combinational; no backpressure.
module round_counter_bank
  import crypto_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int CHANNELS  = 2,
  parameter int MAX_COUNT = 10,
  parameter int SATURATE  = MODE_WRAP,
  localparam int SELW     = sel_width(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SELW-1:0]     ch_sel,
  input  logic                add,
  input  logic                load,
  input  logic [WIDTH-1:0]    load_val,
  input  logic                clr,
  input  logic                show,
  output logic [WIDTH-1:0]    count_out,
  output logic                count_valid,
  output logic [CHANNELS-1:0] done,
  output logic                wrap_pulse
);

  logic [WIDTH-1:0]    counts [CHANNELS];
  logic [CHANNELS-1:0] wrap_vec;
  logic [WIDTH-1:0]    shown;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_cell
    round_counter_cell #(
      .WIDTH     (WIDTH),
      .MAX_COUNT (MAX_COUNT),
      .SATURATE  (SATURATE)
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .sel      (ch_sel == SELW'(i)),
      .add      (add),
      .load     (load),
      .load_val (load_val),
      .clr      (clr),
      .count    (counts[i]),
      .done     (done[i]),
      .wrap     (wrap_vec[i])
    );
  end

  // Out-of-range selects match no channel, so the mux falls through to zero.
  always_comb begin
    shown = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_sel == SELW'(i)) begin
        shown = counts[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_out   <= '0;
      count_valid <= 1'b0;
      wrap_pulse  <= 1'b0;
    end else begin
      if (show) begin
        count_out <= shown;
      end
      count_valid <= show;
      wrap_pulse  <= |wrap_vec;
    end
  end

endmodule

// File: tb/tb_round_counter_bank.sv
// Bench for round_counter_bank: a wrapping 3-channel and a saturating 2-channel instance share one stimulus bus.
module tb_round_counter_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sel;
  logic       add, load, clr, show;
  logic [3:0] val;

  logic [3:0] count_out_w, count_out_s;
  logic       count_valid_w, count_valid_s;
  logic [2:0] done_w;
  logic [1:0] done_s;
  logic       wrap_pulse_w, wrap_pulse_s;

  always #5 clk = ~clk;

  round_counter_bank #(.WIDTH(4), .CHANNELS(3), .MAX_COUNT(10), .SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .ch_sel(sel), .add(add), .load(load), .load_val(val),
    .clr(clr), .show(show), .count_out(count_out_w), .count_valid(count_valid_w),
    .done(done_w), .wrap_pulse(wrap_pulse_w)
  );

  round_counter_bank #(.WIDTH(4), .CHANNELS(2), .MAX_COUNT(10), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .ch_sel(sel[0]), .add(add), .load(load), .load_val(val),
    .clr(clr), .show(show), .count_out(count_out_s), .count_valid(count_valid_s),
    .done(done_s), .wrap_pulse(wrap_pulse_s)
  );

  localparam int MAXC = 10;

  int tests = 0;
  int fails = 0;

  // Reference state: index 0 = wrapping bank (3 channels), 1 = saturating bank (2 channels).
  int m   [2][3];
  int eo  [2];
  int ev  [2];
  int ewr [2];

  typedef struct {
    logic [1:0] sel;
    logic       add, load;
    logic [3:0] val;
    logic       clr, show;
    logic [3:0] eout;
    logic       evld;
    logic [2:0] edone;
    logic       ewrap;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 3; c++) m[k][c] = 0;
      eo[k] = 0; ev[k] = 0; ewr[k] = 0;
    end
  endtask

  task automatic model_clock();
    for (int k = 0; k < 2; k++) begin
      int nch = (k == 0) ? 3 : 2;
      int s   = (k == 0) ? int'(sel) : int'(sel[0]);
      if (show) eo[k] = (s < nch) ? m[k][s] : 0;
      ev[k]  = show ? 1 : 0;
      ewr[k] = 0;
      if (s < nch) begin
        if (clr)       m[k][s] = 0;
        else if (load) m[k][s] = (int'(val) > MAXC) ? MAXC : int'(val);
        else if (add) begin
          if (m[k][s] < MAXC) m[k][s] = m[k][s] + 1;
          else if (k == 1)    m[k][s] = MAXC;
          else begin
            m[k][s] = 0;
            ewr[k]  = 1;
          end
        end
      end
    end
  endtask

  function automatic int done_mask(input int k);
    int r = 0;
    int nch = (k == 0) ? 3 : 2;
    for (int c = 0; c < nch; c++) if (m[k][c] == MAXC) r |= (1 << c);
    return r;
  endfunction

  task automatic check_all();
    chk("w_count_out",   count_out_w,   eo[0]);
    chk("w_count_valid", count_valid_w, ev[0]);
    chk("w_wrap_pulse",  wrap_pulse_w,  ewr[0]);
    chk("w_done",        done_w,        done_mask(0));
    chk("s_count_out",   count_out_s,   eo[1]);
    chk("s_count_valid", count_valid_s, ev[1]);
    chk("s_wrap_pulse",  wrap_pulse_s,  ewr[1]);
    chk("s_done",        done_s,        done_mask(1));
  endtask

  task automatic cyc(input logic [1:0] s, input logic a, input logic l, input logic [3:0] v,
                     input logic c, input logic sh);
    sel = s; add = a; load = l; val = v; clr = c; show = sh;
    @(posedge clk);
    model_clock();
    #1;
    check_all();
  endtask

  initial begin
    int wrap_seen;

    rst = 1'b0; sel = '0; add = 0; load = 0; val = '0; clr = 0; show = 0;
    model_reset();
    #12;
    check_all();
    rst = 1'b1;

    // sel add load val clr show | out vld done wrap   (wrapping bank, counts from reset)
    tbl[0]  = '{2'd0, 1, 0, 4'd0,  0, 0, 4'd0, 0, 3'b000, 0};
    tbl[1]  = '{2'd0, 1, 0, 4'd0,  0, 0, 4'd0, 0, 3'b000, 0};
    tbl[2]  = '{2'd0, 1, 0, 4'd0,  0, 0, 4'd0, 0, 3'b000, 0};
    tbl[3]  = '{2'd0, 0, 0, 4'd0,  0, 1, 4'd3, 1, 3'b000, 0};
    tbl[4]  = '{2'd1, 0, 0, 4'd0,  0, 1, 4'd0, 1, 3'b000, 0};
    tbl[5]  = '{2'd0, 0, 0, 4'd0,  0, 0, 4'd0, 0, 3'b000, 0};
    tbl[6]  = '{2'd0, 0, 1, 4'd5,  0, 0, 4'd0, 0, 3'b000, 0};
    tbl[7]  = '{2'd0, 1, 1, 4'd7,  1, 1, 4'd5, 1, 3'b000, 0};
    tbl[8]  = '{2'd0, 0, 0, 4'd0,  0, 1, 4'd0, 1, 3'b000, 0};
    tbl[9]  = '{2'd2, 0, 1, 4'd14, 0, 0, 4'd0, 0, 3'b100, 0};
    tbl[10] = '{2'd3, 1, 0, 4'd0,  0, 1, 4'd0, 1, 3'b100, 0};
    tbl[11] = '{2'd3, 1, 0, 4'd0,  0, 0, 4'd0, 0, 3'b100, 0};
    tbl[12] = '{2'd2, 1, 0, 4'd0,  0, 0, 4'd0, 0, 3'b000, 1};
    tbl[13] = '{2'd0, 0, 0, 4'd0,  0, 0, 4'd0, 0, 3'b000, 0};

    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].sel, tbl[i].add, tbl[i].load, tbl[i].val, tbl[i].clr, tbl[i].show);
      chk($sformatf("tbl%0d_out", i),  count_out_w,   tbl[i].eout);
      chk($sformatf("tbl%0d_vld", i),  count_valid_w, tbl[i].evld);
      chk($sformatf("tbl%0d_done", i), done_w,        tbl[i].edone);
      chk($sformatf("tbl%0d_wrap", i), wrap_pulse_w,  tbl[i].ewrap);
    end

    // Wrapping bank: eleven adds on ch1 from zero.
    cyc(2'd1, 0, 0, 4'd0, 1, 0);
    for (int i = 1; i <= 11; i++) begin
      cyc(2'd1, 1, 0, 4'd0, 0, 0);
      if (i == 10) begin
        chk("wrap_done_after10", done_w[1], 1);
        chk("wrap_nopulse_after10", wrap_pulse_w, 0);
      end
    end
    chk("wrap_done_after11", done_w[1], 0);
    chk("wrap_pulse_after11", wrap_pulse_w, 1);
    cyc(2'd1, 0, 0, 4'd0, 0, 1);
    chk("wrap_pulse_one_cycle", wrap_pulse_w, 0);
    chk("wrap_count_after11", count_out_w, 0);

    // Saturating bank: fifteen adds on ch0 never wrap.
    cyc(2'd0, 0, 0, 4'd0, 1, 0);
    wrap_seen = 0;
    for (int i = 0; i < 15; i++) begin
      cyc(2'd0, 1, 0, 4'd0, 0, 0);
      if (wrap_pulse_s) wrap_seen = 1;
    end
    cyc(2'd0, 0, 0, 4'd0, 0, 1);
    chk("sat_no_wrap", wrap_seen, 0);
    chk("sat_done0", done_s[0], 1);
    chk("sat_count", count_out_s, 10);

    // Load clamp on the saturating bank.
    cyc(2'd1, 0, 1, 4'd15, 0, 0);
    chk("sat_load_clamp_done", done_s[1], 1);

    // Asynchronous reset in the middle of an add run on ch0 (count 6).
    cyc(2'd0, 0, 0, 4'd0, 1, 0);
    for (int i = 0; i < 6; i++) cyc(2'd0, 1, 0, 4'd0, 0, 1);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("arst_out_immediate", count_out_w, 0);
    add = 0; show = 0;
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
    cyc(2'd0, 1, 0, 4'd0, 0, 0);
    cyc(2'd0, 0, 0, 4'd0, 0, 1);
    chk("arst_first_add", count_out_w, 1);

    // Random traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      logic [1:0] rs;
      logic ra, rl, rc, rh;
      logic [3:0] rv;
      rs = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 99) < 60);
      rl = ($urandom_range(0, 99) < 10);
      rc = ($urandom_range(0, 99) < 5);
      rh = ($urandom_range(0, 99) < 30);
      rv = 4'($urandom_range(0, 15));
      cyc(rs, ra, rl, rv, rc, rh);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
